// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver.
// A start edge is found on the oversample ticks. The start bit is confirmed at
// mid-bit. Each later bit (data, optional parity, stop) is sampled one full
// bit period after the previous sample.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit. PARITY_ODD selects the parity sense.
module uart_rx_os #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clk_rx,
  input  logic                  i_rxd,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_parity_err,
  output logic                  o_busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e                  state_q, state_d;
  logic                    rxd_meta_q, rxd_q;
  logic                    prev_q, prev_d;
  logic [CW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
  logic                    par_err_q, par_err_d;
`endif

  // Two-flop synchronizer on the serial line. It resets to the idle level.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rxd_meta_q <= 1'b1;
      rxd_q      <= 1'b1;
    end else begin
      rxd_meta_q <= i_rxd;
      rxd_q      <= rxd_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      prev_q     <= 1'b1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  // Next-state logic. It advances only on oversample ticks.
  // The pulse outputs default low, so each pulse lasts a single clock.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
`endif
    if (i_clk_rx) begin
      prev_d     = rxd_q;
      tick_cnt_d = tick_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          tick_cnt_d = '0;
          // Start only on a 1 -> 0 transition between ticks.
          // A line held low does not retrigger.
          if (!rxd_q && prev_q) begin
            state_d = START;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
            par_err_d  = 1'b0;
`endif
            state_d    = rxd_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shift_d    = {rxd_q, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            par_err_d  = (rxd_q != ((^shift_q) ^ ODD_BIT));
            state_d    = STOP;
          end
        end
`endif
        STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (rxd_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = par_err_q;
`endif
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16: i_clk_rx ticks per bit, even, legal range 8..32.
REQ-003 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when parity is compiled in.
REQ-004 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_clk_rx  input  1  single-cycle oversample tick enable, OVERSAMPLE x baud rate.
REQ-007 i_rxd  input  1  asynchronous serial line, idle high.
REQ-008 o_data  output  DATA_WIDTH  last good received word, held until the next good frame.
REQ-009 o_valid  output  1  one-i_clk pulse when o_data is updated.
REQ-010 o_frame_err  output  1  one-i_clk pulse on a bad stop bit.
REQ-011 o_parity_err  output  1  one-i_clk pulse on a parity mismatch.
REQ-012 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 i_rxd SHALL pass through a 2-flop synchronizer; the synchronizer resets to 1; every rxd reference below means the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP; all counters and transitions advance only on i_clk cycles where i_clk_rx = 1.
REQ-015 IDLE -> START SHALL occur on a tick where rxd = 0 and the previous tick's sample was 1 (falling edge), so a held-low line never retriggers.
REQ-016 START SHALL count OVERSAMPLE/2 ticks and then sample rxd: 0 -> DATA, 1 -> IDLE (glitch reject) with no output pulse.
REQ-017 DATA SHALL sample rxd every OVERSAMPLE ticks, LSB first, into a DATA_WIDTH shift register; after DATA_WIDTH samples -> PARITY if compiled in, else STOP.
REQ-018 PARITY SHALL sample one bit after OVERSAMPLE ticks and compare it with XOR(data) ^ PARITY_ODD; the mismatch flag is held for STOP.
REQ-019 STOP SHALL sample rxd after OVERSAMPLE ticks and -> IDLE on the same tick.
REQ-020 Stop sample = 1: o_data <= shift register and o_valid = 1 on the next i_clk cycle; o_parity_err pulses in that same cycle if mismatched, and the data is still delivered.
REQ-021 Stop sample = 0: o_frame_err pulses; o_data, o_valid and o_parity_err are unchanged/low.
REQ-022 Latency: o_valid rises exactly one i_clk cycle after the i_clk_rx tick that samples the stop bit.
REQ-023 Back-to-back frames SHALL be accepted: a start edge on the first tick after STOP returns to IDLE is detected.
REQ-024 Pulses SHALL last one i_clk cycle regardless of the tick rate.

Reset
REQ-025 Asserting i_reset low SHALL immediately force IDLE, clear all counters and the shift register, o_data = 0, and o_valid = o_frame_err = o_parity_err = o_busy = 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; after release, reception resumes only on a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: the PARITY state and the parity check are present and the frame is start + DATA_WIDTH + parity + stop.
REQ-028 Macro UART_RX_PARITY_EN undefined: there is no PARITY state, the frame is start + DATA_WIDTH + stop, o_parity_err is tied to 0 and PARITY_ODD is ignored.

Verification (DATA_WIDTH=8, OVERSAMPLE=16, i_clk_rx every 4th i_clk)
REQ-029 Frame 0xA5, stop = 1 -> o_data = 0xA5, exactly one o_valid pulse, o_frame_err = 0, o_busy low after STOP.
REQ-030 rxd low for 3 ticks, then high -> no o_valid or o_frame_err pulse; FSM back in IDLE after START.
REQ-031 Good frame 0x3C, then frame 0x81 with stop = 0 -> o_frame_err pulses once, o_data stays 0x3C, no o_valid.
REQ-032 Parity enabled, even: frame 0x07 with parity bit 0 -> o_valid and o_parity_err in the same cycle, o_data = 0x07.
REQ-033 i_reset low during DATA bit 4, then frame 0x5A -> all outputs 0 during reset, then o_data = 0x5A with a single o_valid.
REQ-034 Frames 0x00 and 0xFF sent back-to-back with no idle gap -> two o_valid pulses, o_data = 0x00 then 0xFF.
